// File: rtl/mips_if_fetch_ctrl.sv
// mips_if_fetch_ctrl: IF-stage fetch sequencer owning the PC, predicting next PC and handling EX redirects
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   ifu_req_*          single-outstanding fetch request (valid/ready/word-aligned addr)
//   ifu_rsp_*          one-cycle instruction return per accepted request
//   if2id_*            output register to ID (valid/ready, inst, pc, pc+4, prediction flag)
//   jr_rs_*            rs index of a pending jr/jalr and the returned register value
//   ex_flush_*         redirect request and target from EX
module mips_if_fetch_ctrl #(
  parameter int MIPS_ADDR_WIDTH = 32,
  parameter int MIPS_INST_WIDTH = 32,
  parameter int MIPS_RFIDX_WIDTH = 5,
  parameter logic [MIPS_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        ifu_req_valid,
  input  logic                        ifu_req_ready,
  output logic [MIPS_ADDR_WIDTH-1:0]  ifu_req_addr,
  input  logic                        ifu_rsp_valid,
  input  logic [MIPS_INST_WIDTH-1:0]  ifu_rsp_inst,
  output logic                        if2id_valid,
  input  logic                        if2id_ready,
  output logic [MIPS_INST_WIDTH-1:0]  if2id_inst,
  output logic [MIPS_ADDR_WIDTH-1:0]  if2id_pc,
  output logic [MIPS_ADDR_WIDTH-1:0]  if2id_pc_incr,
  output logic                        if2id_prdt_taken,
  output logic [MIPS_RFIDX_WIDTH-1:0] jr_rs_idx,
  input  logic                        jr_rs_rdy,
  input  logic [MIPS_ADDR_WIDTH-1:0]  jr_rs_val,
  input  logic                        ex_flush_req,
  input  logic [MIPS_ADDR_WIDTH-1:0]  ex_flush_pc
);
  localparam int AW = MIPS_ADDR_WIDTH;
  localparam int RW = MIPS_RFIDX_WIDTH;
  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(3));
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_JR_WAIT, S_DISCARD} state_t;
  state_t r_state, w_state_nxt;
  logic r_live, r_valid, r_taken, w_valid_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt, r_out_pc, r_out_pc_incr;
  logic [AW-1:0] w_pc_incr, w_j_imm, w_b_imm;
  logic [MIPS_INST_WIDTH-1:0] r_inst;
  logic [RW-1:0] r_rs_idx;
  logic [5:0] w_op, w_funct;
  logic w_is_j, w_is_b, w_is_jr, w_b_back, w_taken, w_fire, w_load, w_pending;
  // IF mini-decoder, fed with the returned instruction and the address after it
  assign w_op      = ifu_rsp_inst[31:26];
  assign w_funct   = ifu_rsp_inst[5:0];
  assign w_pc_incr = r_pc + AW'(4);
  assign w_j_imm   = {w_pc_incr[AW-1:28], ifu_rsp_inst[25:0], 2'b00};
  assign w_b_imm   = {{(AW-18){ifu_rsp_inst[15]}}, ifu_rsp_inst[15:0], 2'b00};
  assign w_is_j    = w_op[5:1] == 5'b00001;
  assign w_is_b    = w_op == 6'b000001 || w_op[5:2] == 4'b0001;
  assign w_is_jr   = w_op == 6'b000000 && w_funct[5:1] == 5'b00100;
  assign w_b_back  = w_is_b && w_b_imm[AW-1];
  assign w_taken   = w_is_j || w_is_jr || w_b_back;
  // r_live keeps the request low until the first clock after reset release
  assign ifu_req_valid = r_live && r_state == S_REQ && (!r_valid || if2id_ready);
  assign ifu_req_addr  = r_pc;
  assign w_fire        = ifu_req_valid && ifu_req_ready;
  assign w_load        = r_state == S_WAIT && ifu_rsp_valid && !ex_flush_req;
  // a request is still in flight after this cycle if it was just accepted or its response has not arrived
  assign w_pending     = (r_state == S_REQ && w_fire) ||
                         ((r_state == S_WAIT || r_state == S_DISCARD) && !ifu_rsp_valid);
  assign if2id_valid      = r_valid;
  assign if2id_inst       = r_inst;
  assign if2id_pc         = r_out_pc;
  assign if2id_pc_incr    = r_out_pc_incr;
  assign if2id_prdt_taken = r_taken;
  assign jr_rs_idx        = r_rs_idx;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = w_load || (r_valid && !if2id_ready);
    if (ex_flush_req) begin
      w_pc_nxt    = ex_flush_pc & ALIGN_MASK;
      w_valid_nxt = 1'b0;
      w_state_nxt = w_pending ? S_DISCARD : S_REQ;
    end else begin
      case (r_state)
        S_REQ:     w_state_nxt = w_fire ? S_WAIT : S_REQ;
        S_WAIT: begin
          if (ifu_rsp_valid) begin
            w_state_nxt = w_is_jr ? S_JR_WAIT : S_REQ;
            w_pc_nxt    = w_is_j ? w_j_imm : w_b_back ? w_pc_incr + w_b_imm : w_is_jr ? r_pc : w_pc_incr;
          end
        end
        S_JR_WAIT: begin
          if (jr_rs_rdy) begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = jr_rs_val & ALIGN_MASK;
          end
        end
        S_DISCARD: w_state_nxt = ifu_rsp_valid ? S_REQ : S_DISCARD;
        default:   w_state_nxt = S_REQ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_live        <= 1'b0;
      r_pc          <= RESET_PC & ALIGN_MASK;
      r_valid       <= 1'b0;
      r_inst        <= '0;
      r_out_pc      <= '0;
      r_out_pc_incr <= '0;
      r_taken       <= 1'b0;
      r_rs_idx      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_load) begin
        r_inst        <= ifu_rsp_inst;
        r_out_pc      <= r_pc;
        r_out_pc_incr <= w_pc_incr;
        r_taken       <= w_taken;
      end
      if (w_load && w_is_jr) r_rs_idx <= RW'(ifu_rsp_inst[25:21]);
    end
  end
endmodule
